ep_tx_arb: RTL and testbench

//  Arbiter/sequencer for the shared PCIe endpoint TRN tx interface. Requesters include mem_rd

---
 rtl/ep_tx_arb_pkg.sv | 18 +
 rtl/ep_tx_arb_rr_pick.sv | 27 ++
 rtl/ep_tx_arb.sv | 118 +++++++++++
 tb/tb_ep_tx_arb.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ep_tx_arb_pkg.sv
// ep_tx_arb_pkg: shared FSM encoding, TRN idle constants and tag width for the tx arbiter
package ep_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } arb_state_t;

    localparam int          TAG_W     = 5;
    localparam logic [63:0] TD_IDLE   = 64'h0;
    localparam logic [7:0]  TREM_IDLE = 8'hFF;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ep_tx_arb_rr_pick.sv
// rr_pick: combinational round-robin picker, searching upward from last+1 with wrap
module rr_pick
    import ep_tx_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    // Walk from the farthest candidate to the nearest so the closest request after last wins
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(last) + k) % N]) begin
                gnt                          = '0;
                gnt[(int'(last) + k) % N]    = 1'b1;
                gnt_idx                      = IW'((int'(last) + k) % N);
            end
        end
    end

endmodule

// File: rtl/ep_tx_arb.sv
// ep_tx_arb: round-robin owner of the shared TRN tx bus plus the global non-posted tag counter
module ep_tx_arb
    import ep_tx_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int TBUF_MIN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_ep,
    input  logic [NREQ-1:0]      drv_ep,
    input  logic [NREQ-1:0]      tag_inc,
    output logic [NREQ-1:0]      my_trn,
    output logic [TAG_W-1:0]     tag_trn,
    input  logic [NREQ*64-1:0]   req_td,
    input  logic [NREQ*8-1:0]    req_trem_n,
    input  logic [NREQ-1:0]      req_tsof_n,
    input  logic [NREQ-1:0]      req_teof_n,
    input  logic [NREQ-1:0]      req_tsrc_rdy_n,
    output logic [63:0]          trn_td,
    output logic [7:0]           trn_trem_n,
    output logic                 trn_tsof_n,
    output logic                 trn_teof_n,
    output logic                 trn_tsrc_rdy_n,
    input  logic [3:0]           trn_tbuf_av,
    output logic                 arb_err
);

    localparam int IW = idx_w(NREQ);

    arb_state_t       state, state_nx;
    logic [IW-1:0]    owner, owner_nx, last, last_nx, pick_idx;
    logic [NREQ-1:0]  pick_gnt, own_mask;
    logic [TAG_W-1:0] tag;
    logic             err, can_grant, req_own, drv_own, tag_own, stray;

    rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .req     (req_ep),
        .last    (last),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx)
    );

    assign own_mask  = (state == IDLE) ? '0 : (NREQ'(1) << owner);
    assign can_grant = (|pick_gnt) && (int'(trn_tbuf_av) >= TBUF_MIN);
    assign req_own   = |(req_ep & own_mask);
    assign drv_own   = |(drv_ep & own_mask);
    assign tag_own   = |(tag_inc & own_mask);
    assign stray     = |((drv_ep | tag_inc) & ~own_mask);
    assign my_trn    = own_mask;
    assign tag_trn   = tag;
    assign arb_err   = err;

    // Grant sequencing: owner is chosen only from IDLE, released on withdrawal or end of drive
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        last_nx  = last;
        case (state)
            IDLE: begin
                if (can_grant) begin
                    state_nx = GRANT;
                    owner_nx = pick_idx;
                end
            end
            GRANT: begin
                if (drv_own) begin
                    state_nx = BUSY;
                end else if (!req_own) begin
                    state_nx = IDLE;
                    last_nx  = owner;
                end
            end
            BUSY: begin
                if (!drv_own) begin
                    state_nx = IDLE;
                    last_nx  = owner;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, owner and round-robin pointer; last starts at NREQ-1 so requester 0 is first
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            owner <= '0;
            last  <= IW'(NREQ - 1);
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            last  <= last_nx;
        end
    end

    // Shared tag counter advances only on the current owner's pulse, wrapping at 5 bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tag <= '0;
        else if (tag_own) tag <= tag + TAG_W'(1);
    end

    // Sticky protocol error on any drive or tag pulse from a requester that is not the owner
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err <= 1'b0;
        else if (stray) err <= 1'b1;
    end

    // Bus mux: owner's TRN signals only while it asserts drv_ep, idle pattern otherwise
    always_comb begin
        trn_td         = drv_own ? req_td[64*int'(owner) +: 64] : TD_IDLE;
        trn_trem_n     = drv_own ? req_trem_n[8*int'(owner) +: 8] : TREM_IDLE;
        trn_tsof_n     = drv_own ? req_tsof_n[owner] : 1'b1;
        trn_teof_n     = drv_own ? req_teof_n[owner] : 1'b1;
        trn_tsrc_rdy_n = drv_own ? req_tsrc_rdy_n[owner] : 1'b1;
    end

endmodule

// File: tb/tb_ep_tx_arb.sv
// tb_ep_tx_arb: directed and randomized checks of ep_tx_arb against an integer-level model
module tb_ep_tx_arb;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req_ep, drv_ep, tag_inc, my_trn;
    logic [N-1:0]    req_tsof_n, req_teof_n, req_tsrc_rdy_n;
    logic [4:0]      tag_trn;
    logic [N*64-1:0] req_td;
    logic [N*8-1:0]  req_trem_n;
    logic [63:0]     trn_td;
    logic [7:0]      trn_trem_n;
    logic            trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n;
    logic [3:0]      trn_tbuf_av;
    logic            arb_err;

    int n_vec = 0;
    int n_err = 0;

    // model: owner index or -1, rr pointer, tag value, has-driven flag, sticky error
    int m_owner, m_last, m_tag;
    bit m_started, m_err;

    ep_tx_arb #(.NREQ(N), .TBUF_MIN(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_ep         (req_ep),
        .drv_ep         (drv_ep),
        .tag_inc        (tag_inc),
        .my_trn         (my_trn),
        .tag_trn        (tag_trn),
        .req_td         (req_td),
        .req_trem_n     (req_trem_n),
        .req_tsof_n     (req_tsof_n),
        .req_teof_n     (req_teof_n),
        .req_tsrc_rdy_n (req_tsrc_rdy_n),
        .trn_td         (trn_td),
        .trn_trem_n     (trn_trem_n),
        .trn_tsof_n     (trn_tsof_n),
        .trn_teof_n     (trn_teof_n),
        .trn_tsrc_rdy_n (trn_tsrc_rdy_n),
        .trn_tbuf_av    (trn_tbuf_av),
        .arb_err        (arb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string t, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", t, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_owner   = -1;
        m_last    = N - 1;
        m_tag     = 0;
        m_started = 0;
        m_err     = 0;
    endfunction

    function automatic void model_step();
        for (int i = 0; i < N; i++)
            if (i != m_owner && (tag_inc[i] || drv_ep[i])) m_err = 1;
        if (m_owner < 0) begin
            if (req_ep != '0 && trn_tbuf_av >= 4'd1) begin
                for (int k = 1; k <= N && m_owner < 0; k++)
                    if (req_ep[(m_last + k) % N]) m_owner = (m_last + k) % N;
                m_started = 0;
            end
        end else begin
            if (tag_inc[m_owner]) m_tag = (m_tag + 1) % 32;
            if (drv_ep[m_owner]) m_started = 1;
            else if (m_started || !req_ep[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
    endfunction

    task automatic check_all();
        logic [N-1:0] et;
        bit on;
        int o;
        o  = (m_owner < 0) ? 0 : m_owner;
        et = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        on = (m_owner >= 0) && drv_ep[o];
        chk("my_trn", 64'(my_trn), 64'(et));
        chk("tag_trn", 64'(tag_trn), 64'(m_tag));
        chk("arb_err", 64'(arb_err), 64'(m_err));
        chk("trn_td", trn_td, on ? req_td[64*o +: 64] : 64'h0);
        chk("trn_trem_n", 64'(trn_trem_n), 64'(on ? req_trem_n[8*o +: 8] : 8'hFF));
        chk("trn_tsof_n", 64'(trn_tsof_n), 64'(on ? req_tsof_n[o] : 1'b1));
        chk("trn_teof_n", 64'(trn_teof_n), 64'(on ? req_teof_n[o] : 1'b1));
        chk("trn_tsrc_rdy_n", 64'(trn_tsrc_rdy_n), 64'(on ? req_tsrc_rdy_n[o] : 1'b1));
    endtask

    task automatic tick();
        for (int i = 0; i < N; i++) begin
            req_td[64*i +: 64]   = {$urandom, $urandom};
            req_trem_n[8*i +: 8] = 8'($urandom);
        end
        req_tsof_n     = N'($urandom);
        req_teof_n     = N'($urandom);
        req_tsrc_rdy_n = N'($urandom);
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        req_ep  = '0;
        drv_ep  = '0;
        tag_inc = '0;
        rst     = 1'b0;
        #1;
        model_reset();
        chk("rst_my_trn", 64'(my_trn), 64'h0);
        chk("rst_tag", 64'(tag_trn), 64'h0);
        chk("rst_err", 64'(arb_err), 64'h0);
        chk("rst_td", trn_td, 64'h0);
        chk("rst_trem", 64'(trn_trem_n), 64'hFF);
        chk("rst_tsrc", 64'(trn_tsrc_rdy_n), 64'h1);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        int r, len;
        len            = 0;
        req_ep         = '0;
        drv_ep         = '0;
        tag_inc        = '0;
        trn_tbuf_av    = 4'd4;
        req_td         = '0;
        req_trem_n     = '1;
        req_tsof_n     = '1;
        req_teof_n     = '1;
        req_tsrc_rdy_n = '1;
        #2;
        do_reset();

        // single requester
        req_ep = 4'b0010;
        tick();
        chk("single_grant", 64'(my_trn), 64'b0010);
        drv_ep = 4'b0010;
        repeat (3) tick();
        drv_ep = '0;
        req_ep = '0;
        tick();
        chk("single_release", 64'(my_trn), 64'h0);

        // contention: four full ownerships then wrap
        do_reset();
        req_ep = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_order", 64'(my_trn), 64'(1) << (k % 4));
            drv_ep = 4'(1 << (k % 4));
            repeat (2) tick();
            drv_ep = '0;
            tick();
            chk("rr_idle_gap", 64'(my_trn), 64'h0);
        end

        // tag wrap from owner 0, then a stray tag pulse
        do_reset();
        req_ep = 4'b0001;
        tick();
        drv_ep = 4'b0001;
        for (int p = 0; p < 33; p++) begin
            chk("tag_seq", 64'(tag_trn), 64'(p % 32));
            tag_inc = 4'b0001;
            tick();
        end
        tag_inc = '0;
        chk("tag_after_33", 64'(tag_trn), 64'd1);
        tag_inc = 4'b0100;
        tick();
        tag_inc = '0;
        chk("tag_nonowner", 64'(tag_trn), 64'd1);
        chk("err_nonowner_tag", 64'(arb_err), 64'h1);
        drv_ep = '0;
        req_ep = '0;
        repeat (2) tick();
        chk("err_sticky", 64'(arb_err), 64'h1);

        // backpressure gates new grants
        do_reset();
        trn_tbuf_av = 4'd0;
        req_ep      = 4'b0001;
        repeat (3) tick();
        chk("bp_no_grant", 64'(my_trn), 64'h0);
        trn_tbuf_av = 4'd1;
        tick();
        chk("bp_grant", 64'(my_trn), 64'b0001);
        req_ep = '0;
        tick();

        // withdrawal before driving
        do_reset();
        req_ep = 4'b1000;
        tick();
        chk("wd_grant3", 64'(my_trn), 64'b1000);
        req_ep = 4'b0001;
        tick();
        chk("wd_idle", 64'(my_trn), 64'h0);
        tick();
        chk("wd_grant0", 64'(my_trn), 64'b0001);
        req_ep = '0;
        tick();

        // asynchronous reset while busy
        req_ep = 4'b0100;
        tick();
        drv_ep = 4'b0100;
        tick();
        req_tsrc_rdy_n      = 4'b0000;
        req_td[128 +: 64]   = 64'hDEAD_BEEF_0123_4567;
        #1;
        chk("busy_td", trn_td, 64'hDEAD_BEEF_0123_4567);
        chk("busy_tsrc", 64'(trn_tsrc_rdy_n), 64'h0);
        rst = 1'b0;
        #1;
        chk("arst_my_trn", 64'(my_trn), 64'h0);
        chk("arst_tsrc", 64'(trn_tsrc_rdy_n), 64'h1);
        chk("arst_td", trn_td, 64'h0);
        model_reset();
        drv_ep = '0;
        req_ep = 4'b1111;
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        chk("post_rst_grant", 64'(my_trn), 64'b0001);

        // randomized traffic from well-behaved requesters
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            trn_tbuf_av = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            tag_inc     = '0;
            drv_ep      = '0;
            for (int i = 0; i < N; i++)
                if (i != m_owner) req_ep[i] = ($urandom_range(0, 2) != 0);
            if (m_owner >= 0) begin
                if (!m_started) begin
                    r = $urandom_range(0, 7);
                    if (r == 0) req_ep[m_owner] = 1'b0;
                    else begin
                        req_ep[m_owner] = 1'b1;
                        if (r >= 4) begin
                            drv_ep[m_owner] = 1'b1;
                            len = $urandom_range(0, 4);
                        end
                    end
                end else if (len > 0) begin
                    drv_ep[m_owner] = 1'b1;
                    len--;
                end
                tag_inc[m_owner] = ($urandom_range(0, 3) == 0);
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
